demo_sequencer: RTL and testbench

Scene scheduler for the demo top level. Counts raster frames from the video path's new_frame pulse and steps through a fixed list of scenes. Each scene has a programmed length. Transitions are brightness fades. Exposes scene index, scene-local frame count, brightness, pause state and music enable, which the field renderer and synth player consume. The two advance buttons give manual skip and pause.

---
 rtl/demo_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_demo_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_sequencer.sv
// Scene scheduler for the demo: counts video frames, steps through a fixed scene list and fades brightness between scenes.
// Build macro DEMO_SEQ_LOOP_EN: wrap from the last scene back to scene 0 instead of stopping in END.
module demo_sequencer #(
    parameter int                              NUM_SCENES       = 4,
    parameter int                              SCENE_BITS       = 2,
    parameter int                              FRAME_BITS       = 10,
    parameter logic [NUM_SCENES*FRAME_BITS-1:0] SCENE_LEN_PACKED = {NUM_SCENES{FRAME_BITS'(512)}},
    parameter int                              FADE_FRAMES      = 8,
    parameter int                              HALF_FPS         = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  new_frame,
    input  logic [1:0]            advance,
    output logic [SCENE_BITS-1:0] scene,
    output logic [FRAME_BITS-1:0] scene_frame,
    output logic [1:0]            brightness,
    output logic                  scene_start,
    output logic                  paused,
    output logic                  music_en
);

`ifdef DEMO_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int STEP_BITS = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_FADE_OUT,
        ST_SWITCH,
        ST_FADE_IN,
        ST_END
    } state_e;

    // ------------------------------------------------------------------
    // Button synchronizers and rising-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_q,  prev_d;
    logic       skip_req;
    logic       pause_req;

    always_comb begin
        sync1_d = advance;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // NOTE: sequential state is always updated with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign skip_req  = sync2_q[0] & ~prev_q[0];
    assign pause_req = sync2_q[1] & ~prev_q[1];

    // ------------------------------------------------------------------
    // Frame tick, optionally halved
    // ------------------------------------------------------------------
    logic tick;

    generate
        if (HALF_FPS != 0) begin : g_half_fps
            logic phase_q, phase_d;

            always_comb begin
                phase_d = new_frame ? ~phase_q : phase_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    phase_q <= 1'b0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            // Phase starts at 0, so the first pulse after reset only arms it.
            assign tick = new_frame & phase_q;
        end else begin : g_full_fps
            assign tick = new_frame;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e                state_q,  state_d;
    logic [SCENE_BITS-1:0] scene_q,  scene_d;
    logic [FRAME_BITS-1:0] frame_q,  frame_d;
    logic [1:0]            bright_q, bright_d;
    logic [STEP_BITS-1:0]  step_q,   step_d;
    logic                  start_q,  start_d;
    logic                  paused_q, paused_d;

    logic [FRAME_BITS-1:0] cur_len;
    logic                  last_frame;
    logic                  last_scene;
    logic                  step_wrap;

    always_comb begin
        cur_len = SCENE_LEN_PACKED[FRAME_BITS-1:0];
        for (int i = 0; i < NUM_SCENES; i++) begin
            if (scene_q == SCENE_BITS'(i)) begin
                cur_len = SCENE_LEN_PACKED[i*FRAME_BITS +: FRAME_BITS];
            end
        end
    end

    assign last_frame = (frame_q == cur_len - FRAME_BITS'(1));
    assign last_scene = (scene_q == SCENE_BITS'(NUM_SCENES - 1));
    assign step_wrap  = (step_q == STEP_BITS'(FADE_FRAMES - 1));

    always_comb begin
        // NOTE: every _d starts from its hold value so no branch can leave a latch behind.
        state_d  = state_q;
        scene_d  = scene_q;
        frame_d  = frame_q;
        bright_d = bright_q;
        step_d   = step_q;
        start_d  = 1'b0;
        paused_d = paused_q;

        if (pause_req && (state_q != ST_END)) begin
            paused_d = ~paused_q;
        end

        case (state_q)
            ST_RUN: begin
                // Skip wins over a same-cycle tick: frame count is not bumped.
                if (skip_req) begin
                    state_d = ST_FADE_OUT;
                    step_d  = '0;
                end else if (tick && !paused_q) begin
                    if (last_frame) begin
                        state_d = ST_FADE_OUT;
                        step_d  = '0;
                    end else begin
                        frame_d = frame_q + FRAME_BITS'(1);
                    end
                end
            end

            ST_FADE_OUT: begin
                if (bright_q == 2'd0) begin
                    step_d = '0;
                    if (last_scene && !LOOP_EN) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_SWITCH;
                        scene_d = last_scene ? '0 : scene_q + SCENE_BITS'(1);
                        frame_d = '0;
                        start_d = 1'b1;
                    end
                end else if (tick) begin
                    if (step_wrap) begin
                        step_d   = '0;
                        bright_d = bright_q - 2'd1;
                    end else begin
                        step_d = step_q + STEP_BITS'(1);
                    end
                end
            end

            ST_SWITCH: begin
                state_d = ST_FADE_IN;
                step_d  = '0;
            end

            ST_FADE_IN: begin
                if (bright_q == 2'd3) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end else if (tick) begin
                    if (step_wrap) begin
                        step_d   = '0;
                        bright_d = bright_q + 2'd1;
                    end else begin
                        step_d = step_q + STEP_BITS'(1);
                    end
                end
            end

            ST_END: begin
                bright_d = 2'd0;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            scene_q  <= '0;
            frame_q  <= '0;
            bright_q <= 2'd3;
            step_q   <= '0;
            start_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            scene_q  <= scene_d;
            frame_q  <= frame_d;
            bright_q <= bright_d;
            step_q   <= step_d;
            start_q  <= start_d;
            paused_q <= paused_d;
        end
    end

    assign scene       = scene_q;
    assign scene_frame = frame_q;
    assign brightness  = bright_q;
    assign scene_start = start_q;
    assign paused      = paused_q;
    assign music_en    = ~paused_q & (state_q != ST_END);

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer: 3 scenes of 4 frames, 2 frames per fade step,
// plus a second instance with the half-rate tick.
module tb_demo_sequencer;

    logic       clk = 1'b0;
    logic       reset_n_a, reset_n_b;
    logic       new_frame_a, new_frame_b;
    logic [1:0] advance_a, advance_b;

    logic [1:0] scene_a, scene_b;
    logic [9:0] frame_a, frame_b;
    logic [1:0] bright_a, bright_b;
    logic       start_a, start_b;
    logic       paused_a, paused_b;
    logic       music_a, music_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    demo_sequencer #(
        .NUM_SCENES(3), .SCENE_BITS(2), .FRAME_BITS(10),
        .SCENE_LEN_PACKED({3{10'd4}}), .FADE_FRAMES(2), .HALF_FPS(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n_a), .new_frame(new_frame_a), .advance(advance_a),
        .scene(scene_a), .scene_frame(frame_a), .brightness(bright_a),
        .scene_start(start_a), .paused(paused_a), .music_en(music_a)
    );

    demo_sequencer #(
        .NUM_SCENES(3), .SCENE_BITS(2), .FRAME_BITS(10),
        .SCENE_LEN_PACKED({3{10'd4}}), .FADE_FRAMES(2), .HALF_FPS(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .new_frame(new_frame_b), .advance(advance_b),
        .scene(scene_b), .scene_frame(frame_b), .brightness(bright_b),
        .scene_start(start_b), .paused(paused_b), .music_en(music_b)
    );

    // All tasks start and end on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_a();
        new_frame_a = 1'b1;
        @(negedge clk);
        new_frame_a = 1'b0;
    endtask

    task automatic ticks_a(input int n);
        repeat (n) tick_a();
    endtask

    task automatic pulse_b();
        new_frame_b = 1'b1;
        @(negedge clk);
        new_frame_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n_a = 1'b0; reset_n_b = 1'b0;
        new_frame_a = 1'b0; new_frame_b = 1'b0;
        advance_a = 2'b00; advance_b = 2'b00;
        idle(2);
        compared++; if (scene_a !== 2'd0)  begin mismatched++; $display("FAIL reset_scene: got %0d want 0", scene_a); end
        compared++; if (frame_a !== 10'd0) begin mismatched++; $display("FAIL reset_frame: got %0d want 0", frame_a); end
        compared++; if (bright_a !== 2'd3) begin mismatched++; $display("FAIL reset_bright: got %0d want 3", bright_a); end
        compared++; if (start_a !== 1'b0)  begin mismatched++; $display("FAIL reset_start: got %b want 0", start_a); end
        compared++; if (paused_a !== 1'b0) begin mismatched++; $display("FAIL reset_paused: got %b want 0", paused_a); end
        compared++; if (music_a !== 1'b1)  begin mismatched++; $display("FAIL reset_music: got %b want 1", music_a); end
        reset_n_a = 1'b1; reset_n_b = 1'b1;
        idle(1);
    endtask

    task automatic test_scene_run();
        logic [1:0] exp_out [6] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        logic [1:0] exp_in  [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        ticks_a(3);
        compared++; if (frame_a !== 10'd3) begin mismatched++; $display("FAIL run_frame3: got %0d want 3", frame_a); end
        compared++; if (bright_a !== 2'd3) begin mismatched++; $display("FAIL run_bright: got %0d want 3", bright_a); end
        tick_a();
        compared++; if (frame_a !== 10'd3) begin mismatched++; $display("FAIL run_last_hold: got %0d want 3", frame_a); end
        for (int i = 0; i < 6; i++) begin
            tick_a();
            compared++;
            if (bright_a !== exp_out[i]) begin
                mismatched++; $display("FAIL fade_out_step%0d: got %0d want %0d", i, bright_a, exp_out[i]);
            end
        end
        compared++; if (scene_a !== 2'd0) begin mismatched++; $display("FAIL fade_out_scene: got %0d want 0", scene_a); end
        idle(1);
        compared++; if (scene_a !== 2'd1) begin mismatched++; $display("FAIL switch_scene: got %0d want 1", scene_a); end
        compared++; if (start_a !== 1'b1) begin mismatched++; $display("FAIL switch_start: got %b want 1", start_a); end
        compared++; if (frame_a !== 10'd0) begin mismatched++; $display("FAIL switch_frame: got %0d want 0", frame_a); end
        idle(1);
        compared++; if (start_a !== 1'b0) begin mismatched++; $display("FAIL start_one_cycle: got %b want 0", start_a); end
        for (int i = 0; i < 6; i++) begin
            tick_a();
            compared++;
            if (bright_a !== exp_in[i]) begin
                mismatched++; $display("FAIL fade_in_step%0d: got %0d want %0d", i, bright_a, exp_in[i]);
            end
        end
        idle(1);
        tick_a();
        compared++; if (frame_a !== 10'd1) begin mismatched++; $display("FAIL run_resume: got %0d want 1", frame_a); end
    endtask

    task automatic test_skip();
        logic [1:0] exp_out [6] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        tick_a();
        compared++; if (frame_a !== 10'd2) begin mismatched++; $display("FAIL skip_pre_frame: got %0d want 2", frame_a); end
        advance_a[0] = 1'b1;
        idle(2);
        // This tick lands on the same edge as the skip pulse.
        tick_a();
        compared++; if (frame_a !== 10'd2) begin mismatched++; $display("FAIL skip_same_cycle: got %0d want 2", frame_a); end
        advance_a[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) advance_a[0] = 1'b1;
            if (i == 4) advance_a[0] = 1'b0;
            tick_a();
            compared++;
            if (bright_a !== exp_out[i]) begin
                mismatched++; $display("FAIL skip_fade_step%0d: got %0d want %0d", i, bright_a, exp_out[i]);
            end
        end
        compared++; if (frame_a !== 10'd2) begin mismatched++; $display("FAIL skip_frame_frozen: got %0d want 2", frame_a); end
        idle(1);
        compared++; if (scene_a !== 2'd2) begin mismatched++; $display("FAIL skip_next_scene: got %0d want 2", scene_a); end
        idle(1);
        ticks_a(6);
        idle(1);
        compared++; if (scene_a !== 2'd2) begin mismatched++; $display("FAIL skip_no_double: got %0d want 2", scene_a); end
        compared++; if (bright_a !== 2'd3) begin mismatched++; $display("FAIL skip_fade_in_done: got %0d want 3", bright_a); end
    endtask

    task automatic test_pause();
        advance_a[1] = 1'b1;
        idle(2);
        compared++; if (paused_a !== 1'b0) begin mismatched++; $display("FAIL pause_early: got %b want 0", paused_a); end
        idle(1);
        compared++; if (paused_a !== 1'b1) begin mismatched++; $display("FAIL pause_set: got %b want 1", paused_a); end
        compared++; if (music_a !== 1'b0)  begin mismatched++; $display("FAIL pause_music: got %b want 0", music_a); end
        ticks_a(10);
        compared++; if (frame_a !== 10'd0) begin mismatched++; $display("FAIL pause_frozen: got %0d want 0", frame_a); end
        advance_a[1] = 1'b0;
        idle(3);
        advance_a[1] = 1'b1;
        idle(3);
        compared++; if (paused_a !== 1'b0) begin mismatched++; $display("FAIL unpause: got %b want 0", paused_a); end
        compared++; if (music_a !== 1'b1)  begin mismatched++; $display("FAIL unpause_music: got %b want 1", music_a); end
        advance_a[1] = 1'b0;
        tick_a();
        compared++; if (frame_a !== 10'd1) begin mismatched++; $display("FAIL unpause_count: got %0d want 1", frame_a); end
    endtask

    task automatic test_end();
        ticks_a(3);
        ticks_a(6);
        compared++; if (bright_a !== 2'd0) begin mismatched++; $display("FAIL last_fade_black: got %0d want 0", bright_a); end
        idle(1);
`ifdef DEMO_SEQ_LOOP_EN
        compared++; if (scene_a !== 2'd0) begin mismatched++; $display("FAIL loop_scene: got %0d want 0", scene_a); end
        compared++; if (start_a !== 1'b1) begin mismatched++; $display("FAIL loop_start: got %b want 1", start_a); end
        idle(1);
        ticks_a(6);
        idle(1);
        compared++; if (bright_a !== 2'd3) begin mismatched++; $display("FAIL loop_fade_in: got %0d want 3", bright_a); end
`else
        advance_a = 2'b11;
        idle(4);
        advance_a = 2'b00;
        idle(3);
        ticks_a(3);
        compared++; if (scene_a !== 2'd2)  begin mismatched++; $display("FAIL end_scene: got %0d want 2", scene_a); end
        compared++; if (bright_a !== 2'd0) begin mismatched++; $display("FAIL end_bright: got %0d want 0", bright_a); end
        compared++; if (music_a !== 1'b0)  begin mismatched++; $display("FAIL end_music: got %b want 0", music_a); end
        compared++; if (paused_a !== 1'b0) begin mismatched++; $display("FAIL end_pause_ignored: got %b want 0", paused_a); end
        compared++; if (start_a !== 1'b0)  begin mismatched++; $display("FAIL end_start: got %b want 0", start_a); end
        compared++; if (frame_a !== 10'd3) begin mismatched++; $display("FAIL end_frame: got %0d want 3", frame_a); end
`endif
    endtask

    task automatic test_half_fps();
        pulse_b();
        compared++; if (frame_b !== 10'd0) begin mismatched++; $display("FAIL half_first_pulse: got %0d want 0", frame_b); end
        pulse_b();
        compared++; if (frame_b !== 10'd1) begin mismatched++; $display("FAIL half_second_pulse: got %0d want 1", frame_b); end
        repeat (6) pulse_b();
        compared++; if (frame_b !== 10'd3) begin mismatched++; $display("FAIL half_eighth_pulse: got %0d want 3", frame_b); end
        compared++; if (bright_b !== 2'd3) begin mismatched++; $display("FAIL half_bright_full: got %0d want 3", bright_b); end
        repeat (4) pulse_b();
        compared++; if (bright_b !== 2'd2) begin mismatched++; $display("FAIL half_fade_step: got %0d want 2", bright_b); end
        compared++; if (frame_b !== 10'd3) begin mismatched++; $display("FAIL half_frame_frozen: got %0d want 3", frame_b); end
    endtask

    task automatic test_async_reset();
        reset_n_a = 1'b0;
        idle(1);
        reset_n_a = 1'b1;
        idle(1);
        ticks_a(4);
        ticks_a(6);
        idle(2);
        ticks_a(3);
        compared++; if (scene_a !== 2'd1)  begin mismatched++; $display("FAIL pre_reset_scene: got %0d want 1", scene_a); end
        compared++; if (bright_a !== 2'd1) begin mismatched++; $display("FAIL pre_reset_bright: got %0d want 1", bright_a); end
        @(posedge clk);
        #2 reset_n_a = 1'b0;
        #1;
        compared++; if (scene_a !== 2'd0)  begin mismatched++; $display("FAIL async_scene: got %0d want 0", scene_a); end
        compared++; if (bright_a !== 2'd3) begin mismatched++; $display("FAIL async_bright: got %0d want 3", bright_a); end
        compared++; if (start_a !== 1'b0)  begin mismatched++; $display("FAIL async_start: got %b want 0", start_a); end
        compared++; if (music_a !== 1'b1)  begin mismatched++; $display("FAIL async_music: got %b want 1", music_a); end
        @(negedge clk);
        reset_n_a = 1'b1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_scene_run();
        test_skip();
        test_pause();
        test_end();
        test_half_fps();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
